instr_encoder: RTL and testbench

Inverse of the control unit's decode. It accepts symbolic instruction requests (class, registers, immediate) over a valid/ready handshake and encodes each one into the 16-bit instruction word that the control unit decodes. It then writes the word sequentially into instruction memory. It sits between the boot/test loader and the imem write port, and rejects requests it cannot encode.

---
 rtl/instr_encoder.sv | 117 +++++++++++
 tb/tb_instr_encoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Encodes symbolic instruction requests into 16-bit control-unit words and
// streams them into instruction memory, rejecting requests that cannot be encoded.
module instr_encoder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [2:0]        req_alu_sel,
  input  logic [2:0]        req_rs,
  input  logic [2:0]        req_rt,
  input  logic [2:0]        req_rd,
  input  logic [11:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count,
  output logic              full
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  function automatic logic [15:0] encode_word(
    input logic [2:0]  kind,
    input logic [2:0]  sel,
    input logic [2:0]  rs,
    input logic [2:0]  rt,
    input logic [2:0]  rd,
    input logic [11:0] imm
  );
    logic [15:0] word;
    case (kind)
      3'd0:    word = {4'b0000, rs, rt, imm[5:0]};
      3'd1:    word = {4'b0001, rs, rt, imm[5:0]};
      3'd2:    word = {4'b0010 + {1'b0, sel}, rs, rt, rd, 3'b000};
      3'd3:    word = {4'b1011, rs, rt, imm[5:0]};
      3'd4:    word = {4'b1100, rs, rt, imm[5:0]};
      3'd5:    word = {4'b1101, imm};
      default: word = 16'h0000;
    endcase
    return word;
  endfunction

  logic              accept_s;
  logic              full_s;
  logic              imm_ok_s;
  logic              needs_imm_s;
  logic [1:0]        reject_code_s;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       wdata_r;
  logic              errv_r;
  logic [1:0]        code_r;
  logic [ADDR_W:0]   count_r;

  assign full_s   = (count_r == DEPTH_C);
  assign accept_s = req_valid && req_ready;

  // Request classification: illegal kind outranks an out-of-range offset
  always_comb begin
    reject_code_s = 2'd0;
    imm_ok_s      = ($signed(req_imm) >= -12'sd32) && ($signed(req_imm) <= 12'sd31);
    needs_imm_s   = (req_kind == 3'd0) || (req_kind == 3'd1) ||
                    (req_kind == 3'd3) || (req_kind == 3'd4);
    if (req_kind > 3'd5) begin
      reject_code_s = 2'd1;
    end else if (needs_imm_s && !imm_ok_s) begin
      reject_code_s = 2'd2;
    end else begin
      reject_code_s = 2'd0;
    end
  end

  // Single output stage plus the accepted-word counter
  always_ff @(posedge clk) begin
    if (reset) begin
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 16'h0000;
      errv_r  <= 1'b0;
      code_r  <= 2'd0;
      count_r <= '0;
    end else begin
      we_r   <= accept_s && (reject_code_s == 2'd0);
      errv_r <= accept_s && (reject_code_s != 2'd0);
      if (accept_s && (reject_code_s == 2'd0)) begin
        addr_r  <= count_r[ADDR_W-1:0];
        wdata_r <= encode_word(req_kind, req_alu_sel, req_rs, req_rt, req_rd, req_imm);
      end
      if (accept_s && (reject_code_s != 2'd0)) begin
        code_r <= reject_code_s;
      end
      if (flush) begin
        count_r <= '0;
      end else if (accept_s && (reject_code_s == 2'd0)) begin
        count_r <= count_r + (ADDR_W+1)'(1);
      end
    end
  end

  // A reset landing on the cycle after an accept must suppress that write
  assign imem_we    = we_r && !reset;
  assign err_valid  = errv_r && !reset;
  assign imem_addr  = addr_r;
  assign imem_wdata = wdata_r;
  assign err_code   = code_r;
  assign word_count = count_r;
  assign full       = full_s;
  assign req_ready  = !full_s && !flush;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder, checked against an opcode-table reference model.
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset, flush, req_valid;
  logic              req_ready;
  logic [2:0]        req_kind, req_alu_sel, req_rs, req_rt, req_rd;
  logic [11:0]       req_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              err_valid;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   word_count;
  logic              full;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the outputs should show after the next edge
  int m_cnt = 0, m_we = 0, m_addr = 0, m_wdata = 0, m_errv = 0, m_code = 0;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_alu_sel(req_alu_sel),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .err_valid(err_valid), .err_code(err_code),
    .word_count(word_count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_error(input int kind, input int imm12);
    int simm;
    simm = (imm12 >= 2048) ? imm12 - 4096 : imm12;
    if (kind > 5) return 1;
    if ((kind == 2) || (kind == 5)) return 0;
    if ((simm < -32) || (simm > 31)) return 2;
    return 0;
  endfunction

  function automatic int ref_encode(input int kind, input int sel, input int rs,
                                    input int rt, input int rd, input int imm12);
    int opcode_of_kind [6] = '{0, 1, 2, 11, 12, 13};
    int op;
    op = (kind == 2) ? 2 + sel : opcode_of_kind[kind];
    if (kind == 5) return op * 4096 + imm12;
    if (kind == 2) return op * 4096 + rs * 512 + rt * 64 + rd * 8;
    return op * 4096 + rs * 512 + rt * 64 + (imm12 % 64);
  endfunction

  // One clock cycle: drive, check mid-cycle against the model, advance the model
  task automatic step(input bit rst, input bit fl, input bit v, input int kind,
                      input int sel, input int rs, input int rt, input int rd, input int imm);
    bit exp_full, exp_ready;
    int e;
    reset = rst; flush = fl; req_valid = v;
    req_kind = 3'(kind); req_alu_sel = 3'(sel); req_rs = 3'(rs);
    req_rt = 3'(rt); req_rd = 3'(rd); req_imm = 12'(imm);
    #4;
    exp_full  = (m_cnt == DEPTH);
    exp_ready = !exp_full && !fl;
    check_val("ready", 32'(req_ready), 32'(exp_ready));
    check_val("full", 32'(full), 32'(exp_full));
    check_val("count", 32'(word_count), 32'(m_cnt));
    check_val("we", 32'(imem_we), rst ? 32'd0 : 32'(m_we));
    check_val("errv", 32'(err_valid), rst ? 32'd0 : 32'(m_errv));
    check_val("addr", 32'(imem_addr), 32'(m_addr));
    check_val("wdata", 32'(imem_wdata), 32'(m_wdata));
    check_val("ecode", 32'(err_code), 32'(m_code));
    if (rst) begin
      m_cnt = 0; m_we = 0; m_errv = 0; m_code = 0; m_addr = 0; m_wdata = 0;
    end else begin
      m_we = 0; m_errv = 0;
      if (v && exp_ready) begin
        e = ref_error(kind, imm);
        if (e != 0) begin
          m_errv = 1; m_code = e;
        end else begin
          m_we = 1; m_addr = m_cnt;
          m_wdata = ref_encode(kind, sel, rs, rt, rd, imm);
          m_cnt++;
        end
      end
      if (fl) m_cnt = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0;
    req_kind = 3'd0; req_alu_sel = 3'd0; req_rs = 3'd0; req_rt = 3'd0; req_rd = 3'd0;
    req_imm = 12'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", 32'(req_ready), 32'd1);
    check_val("rst_we", 32'(imem_we), 32'd0);
    check_val("rst_addr", 32'(imem_addr), 32'd0);
    check_val("rst_wdata", 32'(imem_wdata), 32'd0);
    check_val("rst_errv", 32'(err_valid), 32'd0);
    check_val("rst_ecode", 32'(err_code), 32'd0);
    check_val("rst_count", 32'(word_count), 32'd0);
    check_val("rst_full", 32'(full), 32'd0);

    // LW rs=2 rt=3 imm=-4
    step(0, 0, 1, 0, 0, 2, 3, 0, 12'hFFC);
    check_val("lw_word", 32'(imem_wdata), 32'h04FC);
    check_val("lw_addr", 32'(imem_addr), 32'd0);
    check_val("lw_count", 32'(word_count), 32'd1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);

    // ALU then J back to back
    step(0, 0, 1, 2, 3, 1, 2, 4, 0);
    check_val("alu_word", 32'(imem_wdata), 32'h52A0);
    check_val("alu_addr", 32'(imem_addr), 32'd0);
    check_val("alu_ready", 32'(req_ready), 32'd1);
    step(0, 0, 1, 5, 0, 0, 0, 0, 12'h123);
    check_val("j_word", 32'(imem_wdata), 32'hD123);
    check_val("j_addr", 32'(imem_addr), 32'd1);

    // BNE ok, BEQ out of range, illegal kind
    step(0, 0, 1, 4, 0, 7, 0, 0, 12'hFFF);
    check_val("bne_word", 32'(imem_wdata), 32'hCE3F);
    step(0, 0, 1, 3, 0, 1, 1, 0, 40);
    check_val("beq_errv", 32'(err_valid), 32'd1);
    check_val("beq_code", 32'(err_code), 32'd2);
    check_val("beq_we", 32'(imem_we), 32'd0);
    check_val("beq_count", 32'(word_count), 32'd3);
    step(0, 0, 1, 6, 0, 0, 0, 0, 40);
    check_val("ill_code", 32'(err_code), 32'd1);

    // Fill to DEPTH, hold while full, then flush
    step(0, 0, 1, 1, 0, 3, 4, 0, 5);
    check_val("last_addr", 32'(imem_addr), 32'd3);
    check_val("full_set", 32'(full), 32'd1);
    check_val("full_ready", 32'(req_ready), 32'd0);
    step(0, 0, 1, 0, 0, 1, 1, 0, 1);
    check_val("full_nowrite", 32'(imem_we), 32'd0);
    step(0, 1, 1, 0, 0, 1, 1, 0, 1);
    check_val("flush_count", 32'(word_count), 32'd0);
    step(0, 0, 1, 0, 0, 1, 1, 0, 1);
    check_val("flush_addr", 32'(imem_addr), 32'd0);

    // Reset the cycle after an accept
    step(0, 0, 1, 0, 0, 5, 6, 0, 9);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("mid_rst_we", 32'(imem_we), 32'd0);
    check_val("mid_rst_count", 32'(word_count), 32'd0);
    check_val("mid_rst_wdata", 32'(imem_wdata), 32'd0);
    step(0, 0, 1, 0, 0, 1, 2, 0, 3);
    check_val("post_rst_addr", 32'(imem_addr), 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int imm;
      imm = ($urandom_range(0, 1) == 0) ? ($urandom_range(0, 80) - 40) & 12'hFFF
                                        : int'($urandom_range(0, 4095));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), imm);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
